// File: rtl/cp0_exception_ctrl.sv
// rtl/cp0_exception_ctrl.sv - CP0 SR/Cause/EPC with interrupt/exception entry and eret
module cp0_exception_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h5041_5437
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret_in,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req, exc_req, take;
    logic [31:0] epc_target, sr_val, cause_val;

    // Interrupts look at the raw lines so entry has no sampling latency.
    assign int_req    = ie_q & ~exl_q & (|(hw_int & im_q));
    assign exc_req    = ~exl_q & (exc_code_in != 5'd0);
    assign take       = int_req | exc_req;
    assign epc_target = bd_in ? (pc_in - 32'd4) : pc_in;

    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ip_d       = hw_int;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (take) begin
            exl_d      = 1'b1;
            bd_d       = bd_in;
            exc_code_d = int_req ? 5'd0 : exc_code_in;
            epc_d      = {epc_target[31:2], 2'b00};
        end else begin
            if (we) begin
                case (addr)
                    5'd12: begin
                        im_d  = wdata[15:10];
                        exl_d = wdata[1];
                        ie_d  = wdata[0];
                    end
                    5'd14:   epc_d = {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (eret_in) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= 6'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // While reset is held the registers read as their cleared values.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            5'd12:   rdata = reset ? 32'd0 : sr_val;
            5'd13:   rdata = reset ? 32'd0 : cause_val;
            5'd14:   rdata = reset ? 32'd0 : epc_q;
            5'd15:   rdata = PRID;
            default: rdata = 32'd0;
        endcase
    end

    assign req        = ~reset & take;
    assign handler_pc = HANDLER_PC;
    assign epc_out    = reset ? 32'd0 : epc_q;
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// tb/tb_cp0_exception_ctrl.sv - directed self-checking bench for cp0_exception_ctrl
module tb_cp0_exception_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_int;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret_in;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    cp0_exception_ctrl dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .pc_in(pc_in), .bd_in(bd_in),
        .exc_code_in(exc_code_in), .eret_in(eret_in), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .req(req), .handler_pc(handler_pc),
        .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; hw_int = 6'd0; pc_in = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0;
        eret_in = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
        @(negedge clk);
        tick;
        #1;
        chk("reset_req", {31'd0, req}, 32'd0);
        chk("reset_epc_out", epc_out, 32'd0);
        chk("handler_pc", handler_pc, 32'h0000_4180);
        rd("reset_rd15", 5'd15, 32'h5041_5437);
        rd("reset_rd12", 5'd12, 32'd0);
        reset = 1'b0;
        tick;

        // SR write and readback, same-cycle read returns old value
        we = 1'b1; wdata = 32'h0000_fc01;
        rd("sr_nobypass", 5'd12, 32'd0);
        tick;
        we = 1'b0;
        rd("sr_write", 5'd12, 32'h0000_fc01);

        // interrupt on hw_int[2]
        hw_int = 6'b000100; pc_in = 32'h3010; bd_in = 1'b0;
        #1;
        chk("int_req", {31'd0, req}, 32'd1);
        tick;
        #1;
        chk("int_masked_exl", {31'd0, req}, 32'd0);
        rd("int_epc", 5'd14, 32'h0000_3010);
        rd("int_cause", 5'd13, 32'h0000_1000);
        rd("int_sr", 5'd12, 32'h0000_fc03);
        chk("int_epc_out", epc_out, 32'h0000_3010);

        // clear EXL and IE, then a synchronous exception in a delay slot
        hw_int = 6'd0; we = 1'b1; addr = 5'd12; wdata = 32'h0000_fc00;
        tick;
        we = 1'b0;
        exc_code_in = 5'd12; pc_in = 32'h3024; bd_in = 1'b1;
        #1;
        chk("exc_req", {31'd0, req}, 32'd1);
        tick;
        exc_code_in = 5'd0; bd_in = 1'b0;
        rd("exc_epc", 5'd14, 32'h0000_3020);
        rd("exc_cause", 5'd13, 32'h8000_0030);
        rd("exc_sr", 5'd12, 32'h0000_fc02);

        // EXL masks everything; set IE while still in handler
        hw_int = 6'h3f; exc_code_in = 5'd4; we = 1'b1; addr = 5'd12; wdata = 32'h0000_fc03;
        #1;
        chk("exl_mask", {31'd0, req}, 32'd0);
        tick;
        we = 1'b0; eret_in = 1'b1;
        #1;
        chk("eret_req", {31'd0, req}, 32'd0);
        chk("eret_epc_out", epc_out, 32'h0000_3020);
        tick;
        eret_in = 1'b0; exc_code_in = 5'd0;
        #1;
        chk("post_eret_req", {31'd0, req}, 32'd1);
        chk("post_eret_epc", epc_out, 32'h0000_3020);
        rd("post_eret_sr", 5'd12, 32'h0000_fc01);

        // interrupt beats exception; simultaneous mtc0 discarded
        hw_int = 6'b000001; exc_code_in = 5'd10; pc_in = 32'h3040; bd_in = 1'b0;
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_5550;
        #1;
        chk("prio_req", {31'd0, req}, 32'd1);
        tick;
        hw_int = 6'd0; exc_code_in = 5'd0; we = 1'b0;
        rd("prio_epc", 5'd14, 32'h0000_3040);
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_sr", 5'd12, 32'h0000_fc03);

        // EPC/Cause writes, PRID, unmapped address
        we = 1'b1; addr = 5'd12; wdata = 32'd0;
        tick;
        wdata = 32'h0000_3107;
        rd("epc_nobypass", 5'd14, 32'h0000_3040);
        tick;
        we = 1'b0;
        rd("epc_write", 5'd14, 32'h0000_3104);
        we = 1'b1; addr = 5'd13; wdata = 32'hffff_ffff;
        tick;
        we = 1'b0;
        rd("cause_ro", 5'd13, 32'd0);
        rd("prid", 5'd15, 32'h5041_5437);
        rd("unmapped", 5'd3, 32'd0);

        // reset while in handler
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_3010;
        tick;
        addr = 5'd12; wdata = 32'hffff_ffff;
        tick;
        we = 1'b0;
        rd("sr_mask", 5'd12, 32'h0000_fc03);
        hw_int = 6'h3f; reset = 1'b1;
        #1;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_epc_out", epc_out, 32'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("rst_req_after", {31'd0, req}, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        hw_int = 6'd0;
        tick;
        rd("rst_cause", 5'd13, 32'd0);

        // reset gates a live interrupt request in the same cycle
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_fc01;
        tick;
        we = 1'b0; hw_int = 6'b000100;
        #1;
        chk("live_req", {31'd0, req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("live_req_reset", {31'd0, req}, 32'd0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
